// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register-write controller.
package spi_pkg;

   localparam int   FRAME_BITS = 16;
   localparam int   ADDR_W     = 7;
   localparam int   DATA_W     = 8;
   localparam logic RW_WRITE   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_ctrl_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Request handshake plus SPI pins for one controller; master = requester/bus side, slave = controller.
interface spi_controller_if;
   import spi_pkg::*;

   logic              start;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic              sclk;
   logic              copi;
   logic              ncs;
   logic              cipo;

   modport master (
      output start, rw, addr, wdata, cipo,
      input  busy, done, rdata, sclk, copi, ncs
   );

   modport slave (
      input  start, rw, addr, wdata, cipo,
      output busy, done, rdata, sclk, copi, ncs
   );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: tick_o marks the last clk cycle of each SCLK half-period while enabled.
module spi_half_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW     = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == '0);

   // Held at the reload value while idle so the first half-period after enable is full length.
   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (!en_i || tick_o) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending 16-bit {rw, addr, data} frames MSB first and capturing CIPO.
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input logic             clk,
   input logic             rst_n,
   spi_controller_if.slave bus
);

   localparam logic [4:0] LAST_EDGE = 5'(FRAME_BITS);

   spi_ctrl_state_e       state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [DATA_W-1:0]     rx_q, rx_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [4:0]            bitcnt_q, bitcnt_d;
   logic                  sclk_q, sclk_d;
   logic                  ncs_q, ncs_d;
   logic                  done_q, done_d;
   logic                  tick_en;
   logic                  tick;

   assign tick_en = (state_q != IDLE);

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (tick_en),
      .tick_o (tick)
   );

   assign bus.busy  = tick_en;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;
   assign bus.sclk  = sclk_q;
   assign bus.copi  = shift_q[FRAME_BITS-1];
   assign bus.ncs   = ncs_q;

   // copi is always the shift-register MSB, so shifting only on falling edges keeps it stable across rises.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      bitcnt_d = bitcnt_q;
      sclk_d   = sclk_q;
      ncs_d    = ncs_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d  = {bus.rw, bus.addr, bus.wdata};
               bitcnt_d = '0;
               sclk_d   = 1'b0;
               ncs_d    = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               sclk_d   = 1'b1;
               rx_d     = {rx_q[DATA_W-2:0], bus.cipo};
               bitcnt_d = bitcnt_q + 5'd1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  if (bitcnt_q == LAST_EDGE) begin
                     state_d = HOLD;
                  end else begin
                     shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                  end
               end else begin
                  sclk_d   = 1'b1;
                  rx_d     = {rx_q[DATA_W-2:0], bus.cipo};
                  bitcnt_d = bitcnt_q + 5'd1;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               ncs_d   = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               done_d  = 1'b1;
               rdata_d = rx_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         rx_q     <= '0;
         rdata_q  <= '0;
         bitcnt_q <= '0;
         sclk_q   <= 1'b0;
         ncs_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         rx_q     <= rx_d;
         rdata_q  <= rdata_d;
         bitcnt_q <= bitcnt_d;
         sclk_q   <= sclk_d;
         ncs_q    <= ncs_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench: table vectors, random frames against a register-map model, and hand-written corner sequences.
module tb_spi_controller;
   import spi_pkg::*;

   localparam int CDA = 4;
   localparam int CDB = 1;

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       loop;
      logic [7:0] expRdata;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_controller_if busA();
   spi_controller_if busB();

   spi_controller #(.CLK_DIV(CDA)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
   spi_controller #(.CLK_DIV(CDB)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

   // Bus A: either loopback or a behavioural register-file peripheral; bus B is always loopback.
   logic loopA = 1'b0;
   logic pCipo = 1'b0;
   assign busA.cipo = loopA ? busA.copi : pCipo;
   assign busB.cipo = busB.copi;

   logic [7:0] modelRegs [int];

   // Peripheral: write frames commit on ncs rise only after exactly 16 edges; reads return data in the last byte.
   logic [15:0] pShift = '0;
   int          pCnt   = 0;
   logic        pRw    = 1'b1;
   logic [6:0]  pAddr  = '0;
   logic [7:0]  pRegs [0:127];
   logic [7:0]  pByte;

   always @(posedge busA.sclk or negedge busA.ncs) begin
      if (busA.sclk) begin
         if (!busA.ncs) begin
            pShift = {pShift[14:0], busA.copi};
            pCnt++;
            if (pCnt == 8) begin
               pRw   = pShift[7];
               pAddr = pShift[6:0];
            end
         end
      end else begin
         pCnt = 0;
      end
   end

   always @(negedge busA.sclk) begin
      if (!busA.ncs && !pRw && pCnt >= 8 && pCnt <= 15) begin
         pByte = pRegs[pAddr];
         pCipo = pByte[3'(15 - pCnt)];
      end else begin
         pCipo = 1'b0;
      end
   end

   always @(posedge busA.ncs) begin
      if (pCnt == 16 && pShift[15]) pRegs[pShift[14:8]] = pShift[7:0];
   end

   // Bus A monitor, sampled on the falling clk edge.
   logic        prevSclkA = 1'b0, prevNcsA = 1'b1, prevCopiA = 1'b0;
   logic [15:0] bitsA = '0;
   int          riseCntA = 0, doneCntA = 0, ncsFallCntA = 0, stableErrA = 0;
   int          ncsRiseCycA = 0, ncsFallCycA = 0, doneCycA = 0;
   int          riseCycA[$];

   always @(negedge clk) begin
      if (busA.sclk && !prevSclkA) begin
         riseCntA++;
         riseCycA.push_back(cyc);
         bitsA = {bitsA[14:0], busA.copi};
         if (busA.copi !== prevCopiA) stableErrA++;
      end
      if (busA.ncs && !prevNcsA) ncsRiseCycA = cyc;
      if (!busA.ncs && prevNcsA) begin
         ncsFallCntA++;
         ncsFallCycA = cyc;
      end
      if (busA.done) begin
         doneCntA++;
         doneCycA = cyc;
      end
      prevSclkA = busA.sclk;
      prevNcsA  = busA.ncs;
      prevCopiA = busA.copi;
   end

   // Bus B monitor: per-frame edge counts and ncs transition cycles.
   logic prevSclkB = 1'b0, prevNcsB = 1'b1;
   int   curRisesB = 0, doneCntB = 0;
   int   riseCntQB[$];
   int   ncsRiseQB[$];
   int   ncsFallQB[$];

   always @(negedge clk) begin
      if (busB.sclk && !prevSclkB) curRisesB++;
      if (!busB.ncs && prevNcsB) begin
         ncsFallQB.push_back(cyc);
         curRisesB = 0;
      end
      if (busB.ncs && !prevNcsB) begin
         ncsRiseQB.push_back(cyc);
         riseCntQB.push_back(curRisesB);
      end
      if (busB.done) doneCntB++;
      prevSclkB = busB.sclk;
      prevNcsB  = busB.ncs;
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rwV, input logic [6:0] aV, input logic [7:0] dV,
                                input logic loopV, output int e0);
      @(negedge clk);
      busA.rw    = rwV;
      busA.addr  = aV;
      busA.wdata = dV;
      loopA      = loopV;
      busA.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      e0 = cyc;
      busA.start = 1'b0;
   endtask

   task automatic runFrame(input string tag, input logic rwV, input logic [6:0] aV, input logic [7:0] dV,
                           input logic loopV, input logic [7:0] expRd);
      int   e0, budget, rBase, dBase, sBase;
      logic timingOk;
      rBase = riseCntA;
      dBase = doneCntA;
      sBase = stableErrA;
      applyStimulus(rwV, aV, dV, loopV, e0);
      #1;
      checkOutput({tag, " busy"}, 32'(busA.busy), 32'd1);
      checkOutput({tag, " ncsFallAt"}, 32'(ncsFallCycA - e0), 32'd0);
      budget = 0;
      while (doneCntA == dBase && budget < 40 * CDA) begin
         @(negedge clk);
         #1;
         budget++;
      end
      checkOutput({tag, " done"}, 32'(doneCntA - dBase), 32'd1);
      checkOutput({tag, " doneAt"}, 32'(doneCycA - e0), 32'(34 * CDA));
      checkOutput({tag, " ncsRiseAt"}, 32'(ncsRiseCycA - e0), 32'(33 * CDA));
      checkOutput({tag, " edges"}, 32'(riseCntA - rBase), 32'd16);
      timingOk = 1'b1;
      if (riseCycA.size() < rBase + 16) timingOk = 1'b0;
      else for (int k = 0; k < 16; k++)
         if (riseCycA[rBase + k] - e0 != CDA * (2 * k + 1)) timingOk = 1'b0;
      checkOutput({tag, " riseTiming"}, 32'(timingOk), 32'd1);
      checkOutput({tag, " copiBits"}, 32'(bitsA), 32'({rwV, aV, dV}));
      checkOutput({tag, " copiStable"}, 32'(stableErrA - sBase), 32'd0);
      checkOutput({tag, " busyEnd"}, 32'(busA.busy), 32'd0);
      checkOutput({tag, " rdata"}, 32'(busA.rdata), 32'(expRd));
      @(negedge clk);
      #1;
      checkOutput({tag, " donePulse"}, 32'(busA.done), 32'd0);
      if (rwV == RW_WRITE) modelRegs[int'(aV)] = dV;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         e0, budget, dBase, rBase, fBase, rbB, fbB, dbB;
      vec_t       vecs [12];
      logic [7:0] wrData [5];

      busA.start = 1'b0; busA.rw = 1'b0; busA.addr = '0; busA.wdata = '0;
      busB.start = 1'b0; busB.rw = 1'b0; busB.addr = '0; busB.wdata = '0;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset ncs", 32'(busA.ncs), 32'd1);
      checkOutput("reset sclk", 32'(busA.sclk), 32'd0);
      checkOutput("reset copi", 32'(busA.copi), 32'd0);
      checkOutput("reset busy", 32'(busA.busy), 32'd0);
      checkOutput("reset done", 32'(busA.done), 32'd0);
      checkOutput("reset rdata", 32'(busA.rdata), 32'd0);
      checkOutput("reset ncsB", 32'(busB.ncs), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table: write frame, loopback, five peripheral writes, then read each back.
      wrData  = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81};
      vecs[0] = '{RW_WRITE, 7'h04, 8'hA5, 1'b0, 8'h00};
      vecs[1] = '{RW_WRITE, 7'h00, 8'h3C, 1'b1, 8'h3C};
      for (int i = 0; i < 5; i++) begin
         vecs[2 + i] = '{RW_WRITE, 7'(i), wrData[i], 1'b0, 8'h00};
         vecs[7 + i] = '{~RW_WRITE, 7'(i), 8'h00, 1'b0, wrData[i]};
      end
      for (int i = 0; i < 12; i++)
         runFrame($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].loop, vecs[i].expRdata);

      // start pulses while busy are dropped; input changes after accept do not leak into the frame.
      dBase = doneCntA;
      rBase = riseCntA;
      fBase = ncsFallCntA;
      applyStimulus(RW_WRITE, 7'h12, 8'h96, 1'b0, e0);
      busA.rw = 1'b0; busA.addr = 7'h7F; busA.wdata = 8'h00;
      while (cyc < e0 + 10) @(negedge clk);
      busA.start = 1'b1;
      @(negedge clk);
      busA.start = 1'b0;
      while (cyc < e0 + 100) @(negedge clk);
      busA.start = 1'b1;
      @(negedge clk);
      busA.start = 1'b0;
      budget = 0;
      while (doneCntA == dBase && budget < 40 * CDA) begin
         @(negedge clk);
         #1;
         budget++;
      end
      repeat (20) @(negedge clk);
      #1;
      checkOutput("ignore doneCount", 32'(doneCntA - dBase), 32'd1);
      checkOutput("ignore edges", 32'(riseCntA - rBase), 32'd16);
      checkOutput("ignore ncsFalls", 32'(ncsFallCntA - fBase), 32'd1);
      checkOutput("ignore copiBits", 32'(bitsA), 32'({1'b1, 7'h12, 8'h96}));
      modelRegs[18] = 8'h96;

      // Reset mid-frame: bus idles immediately, no done, and the peripheral discards the partial write.
      dBase = doneCntA;
      applyStimulus(RW_WRITE, 7'h00, 8'hEE, 1'b0, e0);
      while (cyc < e0 + 50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midReset ncs", 32'(busA.ncs), 32'd1);
      checkOutput("midReset sclk", 32'(busA.sclk), 32'd0);
      checkOutput("midReset busy", 32'(busA.busy), 32'd0);
      checkOutput("midReset copi", 32'(busA.copi), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("midReset noDone", 32'(doneCntA - dBase), 32'd0);
      checkOutput("midReset rdata", 32'(busA.rdata), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      runFrame("postReset read0", ~RW_WRITE, 7'h00, 8'h00, 1'b0, modelRegs[0]);
      runFrame("postReset write", RW_WRITE, 7'h05, 8'h7E, 1'b0, 8'h00);

      // Random traffic checked against the register-map model.
      for (int i = 0; i < 20; i++) begin
         logic       rwR;
         logic [6:0] aR;
         logic [7:0] dR, expR;
         rwR = 1'($urandom_range(0, 1));
         aR  = 7'($urandom_range(0, 7));
         dR  = 8'($urandom);
         if (!rwR && !modelRegs.exists(int'(aR))) rwR = 1'b1;
         expR = rwR ? 8'h00 : modelRegs[int'(aR)];
         runFrame($sformatf("rand%0d", i), rwR, aR, dR, 1'b0, expR);
      end

      // Back-to-back frames on the CLK_DIV=1 instance with start held high.
      rbB = ncsRiseQB.size();
      fbB = ncsFallQB.size();
      dbB = doneCntB;
      @(negedge clk);
      busB.rw = RW_WRITE; busB.addr = 7'h2A; busB.wdata = 8'h69; busB.start = 1'b1;
      budget = 0;
      while (doneCntB < dbB + 3 && budget < 300) begin
         @(negedge clk);
         #1;
         budget++;
      end
      busB.start = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checkOutput("b2b doneCount", 32'(doneCntB - dbB), 32'd3);
      checkOutput("b2b frames", 32'(ncsRiseQB.size() - rbB), 32'd3);
      if (ncsRiseQB.size() - rbB >= 3 && ncsFallQB.size() - fbB >= 3) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("b2b edges%0d", i), 32'(riseCntQB[rbB + i]), 32'd16);
            checkOutput($sformatf("b2b ncsLow%0d", i), 32'(ncsRiseQB[rbB + i] - ncsFallQB[fbB + i]), 32'd33);
         end
         for (int i = 0; i < 2; i++)
            checkOutput($sformatf("b2b ncsHigh%0d", i), 32'(ncsFallQB[fbB + i + 1] - ncsRiseQB[rbB + i]), 32'd2);
      end
      checkOutput("b2b busyEnd", 32'(busB.busy), 32'd0);
      checkOutput("b2b rdata", 32'(busB.rdata), 32'h69);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
